// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared FSM state encoding and default game constants
package button_pkg;

    localparam int unsigned LOCKOUT_CYCLES_DEF = 8;
    localparam int unsigned WIN_SCORE_DEF      = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_LOCKOUT,
        ST_WAIT_REL,
        ST_DONE
    } state_t;

endpackage

// File: rtl/button_pulse.sv
// rtl/button_pulse.sv - 2-flop synchronizer plus rising-edge press detector for one button
module button_pulse (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse,
    output logic level
);
    logic       sync1;
    logic       sync2;
    logic       prev;
    logic [1:0] settle;
    logic       armed;

    // armed stays low until the synchronized key is seen released, so a button
    // held through reset cannot produce a press when reset lets go
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            prev   <= 1'b0;
            settle <= 2'b00;
            armed  <= 1'b0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            prev   <= sync2;
            settle <= {settle[0], 1'b1};
            if (settle[1] && !sync2) begin
                armed <= 1'b1;
            end
        end
    end

    assign pulse = sync2 & ~prev & armed;
    assign level = sync2;

endmodule

// File: rtl/button_arbiter.sv
// rtl/button_arbiter.sv - two-player buzzer arbiter with lockout, scoring and game end
module button_arbiter
    import button_pkg::*;
#(
    parameter int unsigned LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF,
    parameter int unsigned WIN_SCORE      = WIN_SCORE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] key,
    output logic [1:0] grant,
    output logic       busy,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic       game_over
);
    localparam logic [3:0] WIN  = 4'(WIN_SCORE);
    localparam logic [7:0] LOAD = 8'(LOCKOUT_CYCLES - 1);

    logic [1:0] press;
    logic [1:0] level;
    state_t     state;
    logic       last;
    logic [7:0] cnt;
    logic       pick;
    logic [3:0] win_cur;
    logic [3:0] win_next;

    button_pulse u_pulse0 (.clk(clk), .reset(reset), .raw(key[0]), .pulse(press[0]), .level(level[0]));
    button_pulse u_pulse1 (.clk(clk), .reset(reset), .raw(key[1]), .pulse(press[1]), .level(level[1]));

    // on a tie the player who did not win last time gets the point
    always_comb begin
        pick     = (press == 2'b11) ? ~last : press[1];
        win_cur  = last ? score1 : score0;
        win_next = (win_cur >= WIN) ? WIN : win_cur + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            grant     <= 2'b00;
            busy      <= 1'b0;
            score0    <= 4'd0;
            score1    <= 4'd0;
            game_over <= 1'b0;
            last      <= 1'b1;
            cnt       <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|press) begin
                        state <= ST_GRANT;
                        grant <= pick ? 2'b10 : 2'b01;
                        last  <= pick;
                        busy  <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    grant <= 2'b00;
                    if (last) score1 <= win_next;
                    else      score0 <= win_next;
                    if (win_next == WIN) begin
                        state     <= ST_DONE;
                        busy      <= 1'b0;
                        game_over <= 1'b1;
                    end else begin
                        state <= ST_LOCKOUT;
                        cnt   <= LOAD;
                    end
                end
                ST_LOCKOUT: begin
                    if (cnt == 8'd0) state <= ST_WAIT_REL;
                    else             cnt   <= cnt - 8'd1;
                end
                ST_WAIT_REL: begin
                    if (level == 2'b00) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    grant     <= 2'b00;
                    busy      <= 1'b0;
                    game_over <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_arbiter.sv
// tb/tb_button_arbiter.sv - directed self-checking bench for button_arbiter
module tb_button_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] key;
    logic [1:0] grant;
    logic       busy;
    logic [3:0] score0;
    logic [3:0] score1;
    logic       game_over;

    int errors = 0;
    int checks = 0;
    int g0 = 0;
    int g1 = 0;
    int bad_grant = 0;

    button_arbiter #(.LOCKOUT_CYCLES(8), .WIN_SCORE(7)) dut (
        .clk(clk), .reset(reset), .key(key), .grant(grant), .busy(busy),
        .score0(score0), .score1(score1), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (grant == 2'b11) bad_grant++;
        if (grant[0]) g0++;
        if (grant[1]) g1++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        ticks(4);
        g0 = 0;
        g1 = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (busy) check(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_s0"}, 32'(score0), 32'd0);
        check({tag, "_s1"}, 32'(score1), 32'd0);
        check({tag, "_go"}, 32'(game_over), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        key   = 2'b00;
        ticks(2);
        check_reset_outputs("in_reset");

        // single press held for 10 cycles: one grant at the third sampling edge
        do_reset();
        check_reset_outputs("post_reset");
        check("idle_busy", 32'(busy), 32'd0);
        key = 2'b01;
        ticks(2);
        check("lat_edge2", 32'(grant), 32'd0);
        tick();
        check("lat_edge3", 32'(grant), 32'h1);
        check("busy_grant", 32'(busy), 32'd1);
        tick();
        check("grant_1cyc", 32'(grant), 32'd0);
        check("score0_one", 32'(score0), 32'd1);
        ticks(6);
        key = 2'b00;
        wait_idle("t1_idle");
        check("t1_g0", 32'(g0), 32'd1);
        check("t1_g1", 32'(g1), 32'd0);

        // ties alternate starting with player 0
        do_reset();
        key = 2'b11;
        ticks(3);
        check("tie1", 32'(grant), 32'h1);
        key = 2'b00;
        wait_idle("t2_idle_a");
        key = 2'b11;
        ticks(3);
        check("tie2", 32'(grant), 32'h2);
        key = 2'b00;
        wait_idle("t2_idle_b");
        check("tie_s0", 32'(score0), 32'd1);
        check("tie_s1", 32'(score1), 32'd1);

        // player 1 pulses during lockout are discarded
        do_reset();
        key = 2'b01;
        ticks(3);
        check("lk_grant0", 32'(grant), 32'h1);
        key = 2'b00;
        ticks(3);
        key = 2'b10;
        ticks(2);
        key = 2'b00;
        wait_idle("t3_idle_a");
        check("lk_discard", 32'(g1), 32'd0);
        key = 2'b10;
        ticks(3);
        check("lk_after", 32'(grant), 32'h2);
        key = 2'b00;
        wait_idle("t3_idle_b");
        check("lk_s0", 32'(score0), 32'd1);
        check("lk_s1", 32'(score1), 32'd1);

        // seven player-1 wins end the game
        do_reset();
        for (int i = 0; i < 7; i++) begin
            key = 2'b10;
            ticks(3);
            check($sformatf("win%0d", i), 32'(grant), 32'h2);
            key = 2'b00;
            wait_idle("t4_idle");
        end
        check("done_s1", 32'(score1), 32'd7);
        check("done_go", 32'(game_over), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        g0 = 0;
        g1 = 0;
        key = 2'b10;
        ticks(5);
        key = 2'b00;
        ticks(5);
        key = 2'b01;
        ticks(5);
        key = 2'b00;
        ticks(3);
        check("done_nogrant", 32'(g0 + g1), 32'd0);
        check("done_s1_hold", 32'(score1), 32'd7);
        check("done_s0_hold", 32'(score0), 32'd0);

        // reset in lockout with key0 held, then release and re-press
        do_reset();
        key = 2'b01;
        ticks(3);
        check("rl_grant", 32'(grant), 32'h1);
        ticks(3);
        reset = 1'b1;
        ticks(2);
        check_reset_outputs("rl_reset");
        reset = 1'b0;
        g0 = 0;
        g1 = 0;
        ticks(10);
        check("rl_held", 32'(g0), 32'd0);
        key = 2'b00;
        ticks(4);
        key = 2'b01;
        ticks(3);
        check("rl_repress", 32'(grant), 32'h1);
        key = 2'b00;
        wait_idle("t5_idle");

        // glitches that never span a rising edge are ignored
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            #1 key = (i % 2 == 0) ? 2'b01 : 2'b10;
            #2 key = 2'b00;
        end
        ticks(5);
        check("glitch_none", 32'(g0 + g1), 32'd0);
        check("glitch_busy", 32'(busy), 32'd0);
        check("never_11", 32'(bad_grant), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_arbiter.md
BUTTON_ARBITER -- requirements
Module: button_arbiter

Interface
REQ-001 Parameter LOCKOUT_CYCLES, default 8: cycles both players are locked out after a grant, legal range 1..255.
REQ-002 Parameter WIN_SCORE, default 7: score at which the game ends, legal range 1..15.
REQ-003 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset; no asynchronous reset path exists.
REQ-005 Port key  input  2  raw active-high player buttons, asynchronous to clk; bit 0 is player 0 and bit 1 is player 1.
REQ-006 Port grant  output  2  one-hot, one-cycle pulse identifying the player awarded a point.
REQ-007 Port busy  output  1  high while in GRANT, LOCKOUT or WAIT_REL.
REQ-008 Port score0, score1  output  4 each  per-player point counts.
REQ-009 Port game_over  output  1  high once either score equals WIN_SCORE.

Function
REQ-010 Each key bit shall pass through a 2-flop synchronizer, then a rising-edge detector producing a one-cycle press pulse.
REQ-011 A held button shall generate exactly one press pulse per low-to-high transition.
REQ-012 FSM states: IDLE, GRANT, LOCKOUT, WAIT_REL, DONE.
REQ-013 IDLE: any press pulse -> GRANT with grant bit registered; no pulse -> stay in IDLE.
REQ-014 Latency: grant shall be high exactly in the cycle after the 3rd rising clk edge at which key is sampled high, counting the first sampling edge as the 1st.
REQ-015 Simultaneous press pulses in IDLE shall go to the player who did not win the last grant (round-robin); the internal last-winner bit resets to 1, so player 0 wins the first tie.
REQ-016 GRANT lasts one cycle: winner score increments by 1; next state is DONE if the new score equals WIN_SCORE, otherwise LOCKOUT.
REQ-017 LOCKOUT: a counter loaded with LOCKOUT_CYCLES-1 decrements each cycle; press pulses are discarded, not queued; at 0 -> WAIT_REL.
REQ-018 WAIT_REL: stay until both synchronized keys are low, then -> IDLE; a button held through lockout shall never produce a grant.
REQ-019 DONE: grant stays 0 and scores hold until reset; busy = 0 and game_over = 1.
REQ-020 Scores shall saturate at WIN_SCORE and never wrap.

Reset
REQ-021 When reset is sampled high: state = IDLE, grant = 0, busy = 0, score0 = score1 = 0, game_over = 0, last-winner = 1, lockout counter = 0, synchronizer and edge flops = 0.
REQ-022 Reset shall take priority over every transition, including mid-GRANT and mid-LOCKOUT.
REQ-023 A button held through reset release shall not generate a press until it is released and pressed again.

Structure
REQ-024 A shared package button_pkg shall hold the FSM state enum and default constants LOCKOUT_CYCLES_DEF = 8 and WIN_SCORE_DEF = 7.
REQ-025 Sub-module button_pulse (clk, reset, raw, pulse, level) shall contain the synchronizer and edge detector, instantiated once per player.
REQ-026 The arbiter FSM, counter and scores shall reside in button_arbiter.

Verification
REQ-027 Reset, then key = 01 held for 10 cycles -> grant = 01 for one cycle at the REQ-014 latency, score0 = 1, no second grant.
REQ-028 Reset, key = 11 on the same edge -> grant = 01; release both, wait for IDLE, key = 11 again -> grant = 10; scores 1/1.
REQ-029 Player 0 wins, then key1 pulses during LOCKOUT (LOCKOUT_CYCLES = 8) -> no grant; key1 pressed after IDLE -> grant = 10.
REQ-030 Seven separate player-1 wins -> score1 = 7, game_over = 1, state DONE; further presses -> grant stays 00.
REQ-031 Reset asserted during LOCKOUT with key0 held -> all outputs at reset values; no grant until key0 is released and re-pressed.
REQ-032 Key pulses shorter than one clk period between edges -> no grant; the bench also checks grant is never 11 and busy is low in IDLE.
